// File: rtl/equiv_check_ctrl.sv
// rtl/equiv_check_ctrl.sv - exhaustive-vector equivalence sequencer (optional STOP_ON_FAIL_EN)
module equiv_check_ctrl #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            f_dut,
    input  logic            f_ref,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            fail_valid
);
    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t          state;
    logic [3:0]      settle_cnt;
    logic            mismatch;
    logic [N_IN:0]   cnt_next;
    logic            last_vec;

    // Case-inequality so that X/Z from a broken student circuit counts as a failure.
    assign mismatch = (f_dut !== f_ref);
    assign cnt_next = mismatch_cnt + {{N_IN{1'b0}}, mismatch};
    assign last_vec = (vec_out == {N_IN{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            settle_cnt     <= 4'd0;
            vec_out        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_vec <= '0;
            fail_valid     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mismatch_cnt   <= '0;
                        first_fail_vec <= '0;
                        fail_valid     <= 1'b0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        vec_out        <= '0;
                        busy           <= 1'b1;
                        state          <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (SETTLE > 0) begin
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_SETTLE;
                    end else begin
                        state <= S_CHECK;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    mismatch_cnt <= cnt_next;
                    if (mismatch && !fail_valid) begin
                        first_fail_vec <= vec_out;
                        fail_valid     <= 1'b1;
                    end
`ifdef STOP_ON_FAIL_EN
                    if (mismatch) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else if (last_vec) begin
`else
                    if (last_vec) begin
`endif
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (cnt_next == '0);
                    end else begin
                        vec_out <= vec_out + 1'b1;
                        state   <= S_APPLY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_equiv_check_ctrl.sv
// tb/tb_equiv_check_ctrl.sv - self-checking bench for equiv_check_ctrl
module tb_equiv_check_ctrl;
    localparam int N_IN   = 4;
    localparam int SETTLE = 1;
    localparam int NV     = 1 << N_IN;
    localparam int PERIOD = 2 + SETTLE;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [N_IN-1:0] vec_out;
    logic            f_dut;
    logic            f_ref;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   mismatch_cnt;
    logic [N_IN-1:0] first_fail_vec;
    logic            fail_valid;

    logic [NV-1:0]   truth;
    logic [NV-1:0]   err_mask;

    int n_checks = 0;
    int n_pass   = 0;

    equiv_check_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_out),
        .f_dut(f_dut), .f_ref(f_ref), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .first_fail_vec(first_fail_vec),
        .fail_valid(fail_valid)
    );

    always #5 clk = ~clk;

    // Reference is an arbitrary truth table; the DUT differs wherever err_mask is set.
    assign f_ref = truth[vec_out];
    assign f_dut = f_ref ^ err_mask[vec_out];

    typedef struct {
        logic [NV-1:0] mask;
        int            poke;
        int            abort;
        int            exp_cnt;
        int            exp_first;
    } row_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vec"}, int'(vec_out), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_cnt"}, int'(mismatch_cnt), 0);
        chk({tag, "_first"}, int'(first_fail_vec), 0);
        chk({tag, "_fv"}, int'(fail_valid), 0);
    endtask

    task automatic run_sweep(input logic [NV-1:0] mask, input int poke, input int abort,
                             input int exp_cnt_in, input int exp_first);
        int edges;
        int busy_bad;
        int exp_cnt;
        int exp_edge;
        int exp_vec;
        err_mask = mask;
        truth    = NV'($urandom);
        exp_cnt  = exp_cnt_in;
        exp_edge = NV * PERIOD;
        exp_vec  = NV - 1;
`ifdef STOP_ON_FAIL_EN
        if (exp_cnt > 0) begin
            exp_cnt  = 1;
            exp_edge = (exp_first + 1) * PERIOD;
            exp_vec  = exp_first;
        end
`endif
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_done", int'(done), 0);
        chk("start_cnt", int'(mismatch_cnt), 0);
        chk("start_fv", int'(fail_valid), 0);
        chk("start_vec", int'(vec_out), 0);
        edges    = 0;
        busy_bad = 0;
        while (edges < 400) begin
            if (edges + 1 == poke) start = 1'b1;
            @(posedge clk);
            edges++;
            #1 start = 1'b0;
            if (edges == abort) begin
                rst_n = 1'b0;
                #1 chk_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done) break;
            if (!busy) busy_bad++;
        end
        chk("done_edge", edges, exp_edge);
        chk("busy_during", busy_bad, 0);
        chk("busy_end", int'(busy), 0);
        chk("done", int'(done), 1);
        chk("cnt", int'(mismatch_cnt), exp_cnt);
        chk("first", int'(first_fail_vec), exp_first);
        chk("fail_valid", int'(fail_valid), (exp_cnt > 0) ? 1 : 0);
        chk("pass", int'(pass), (exp_cnt == 0) ? 1 : 0);
        chk("vec_hold", int'(vec_out), exp_vec);
    endtask

    row_t rows[7];

    initial begin
        rows[0] = '{mask: 16'h0000, poke: 0,  abort: 0,  exp_cnt: 0,  exp_first: 0};
        rows[1] = '{mask: 16'h0020, poke: 0,  abort: 0,  exp_cnt: 1,  exp_first: 5};
        rows[2] = '{mask: 16'hFFFF, poke: 0,  abort: 0,  exp_cnt: 16, exp_first: 0};
        rows[3] = '{mask: 16'h0010, poke: 0,  abort: 20, exp_cnt: 1,  exp_first: 4};
        rows[4] = '{mask: 16'h0020, poke: 0,  abort: 0,  exp_cnt: 1,  exp_first: 5};
        rows[5] = '{mask: 16'h8001, poke: 10, abort: 0,  exp_cnt: 2,  exp_first: 0};
        rows[6] = '{mask: 16'h8000, poke: 0,  abort: 0,  exp_cnt: 1,  exp_first: 15};

        rst_n    = 1'b0;
        start    = 1'b0;
        truth    = '0;
        err_mask = '0;
        #1 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_sweep(rows[i].mask, rows[i].poke, rows[i].abort,
                      rows[i].exp_cnt, rows[i].exp_first);

        // Random mismatch sets scored by popcount / lowest set index.
        for (int r = 0; r < 6; r++) begin
            logic [NV-1:0] m;
            int cnt;
            int first;
            m     = NV'($urandom & $urandom & $urandom);
            cnt   = 0;
            first = -1;
            for (int v = 0; v < NV; v++) begin
                if (m[v]) begin
                    cnt++;
                    if (first < 0) first = v;
                end
            end
            if (first < 0) first = 0;
            run_sweep(m, (r == 2) ? 7 : 0, 0, cnt, first);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
